// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg: shared types and address-width helpers for unified_mem_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned WORD_AW             = $clog2(DEFAULT_DEPTH_WORDS);

  function automatic int unsigned word_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sp_ram: single-port byte-enabled RAM, synchronous write and read. Rev 1.0
// ---------------------------------------------------------------------------
module sp_ram
  import mem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned AW          = WORD_AW
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [XLEN/8-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < XLEN/8; b++) begin
          if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// unified_mem_ctrl: arbitrates fetch and data ports onto one sp_ram. Rev 1.0
// ---------------------------------------------------------------------------
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              stall
);

  localparam int unsigned AW        = word_aw(DEPTH_WORDS);
  localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0]  LAST      = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d, pick, cur_gnt;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, cur_addr, cur_wdata;
  logic [XLEN/8-1:0] be_q, be_d, cur_be;
  logic              we_q, we_d, cur_we, cur_err;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic              if_show_q, if_show_d, d_show_q, d_show_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              any_req, decide, finish, ram_en;
  logic [XLEN-1:0]   ram_rdata;

  always_comb begin
    any_req = if_req | d_req;
    pick    = d_req ? GNT_D : GNT_I;
    decide  = (state_q != ST_ACCESS);
    // A zero-wait op completes in its grant cycle, so it must use the live port values.
    if (decide) begin
      cur_gnt   = pick;
      cur_addr  = (pick == GNT_D) ? d_addr : if_addr;
      cur_we    = (pick == GNT_D) & d_we;
      cur_be    = d_be;
      cur_wdata = d_wdata;
    end else begin
      cur_gnt   = gnt_q;
      cur_addr  = addr_q;
      cur_we    = we_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
    end
    cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (AW + 2)) != '0);
    finish  = decide ? (any_req && ZERO_WAIT) : (cnt_q == LAST);
    ram_en  = finish && !cur_err;

    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    d_err_d    = 1'b0;
    if_show_d  = 1'b0;
    d_show_d   = 1'b0;
    if_rdata_d = if_show_q ? ram_rdata : if_rdata_q;
    d_rdata_d  = d_show_q ? ram_rdata : d_rdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (any_req) begin
          gnt_d   = pick;
          addr_d  = cur_addr;
          we_d    = cur_we;
          be_d    = cur_be;
          wdata_d = cur_wdata;
          cnt_d   = 4'd0;
          state_d = ZERO_WAIT ? ST_RESP : ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (finish) state_d = ST_RESP;
        else        cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      if (cur_gnt == GNT_D) begin
        d_valid_d = 1'b1;
        d_err_d   = cur_err;
        if (cur_err)     d_rdata_d = '0;
        else if (!cur_we) d_show_d = 1'b1;
      end else begin
        if_valid_d = 1'b1;
        if (cur_err) if_rdata_d = '0;
        else         if_show_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= GNT_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
      if_show_q  <= 1'b0;
      d_show_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      d_err_q    <= d_err_d;
      if_show_q  <= if_show_d;
      d_show_q   <= d_show_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  sp_ram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_we),
    .be    (cur_be),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign d_err    = d_err_q;
  assign if_rdata = if_show_q ? ram_rdata : if_rdata_q;
  assign d_rdata  = d_show_q ? ram_rdata : d_rdata_q;
  assign stall    = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_unified_mem_ctrl: directed bench, WAIT_STATES=2 main DUT plus a zero-wait DUT. Rev 1.0
// ---------------------------------------------------------------------------
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] if_rdata, d_rdata;
  logic        if_valid, d_valid, d_err, stall;

  logic        z_d_req = 1'b0, z_d_we = 1'b0;
  logic [31:0] z_d_addr = '0, z_d_wdata = '0;
  logic [3:0]  z_d_be = '0;
  logic [31:0] z_if_rdata, z_d_rdata;
  logic        z_if_valid, z_d_valid, z_d_err, z_stall;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .stall(stall)
  );

  unified_mem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(z_if_rdata), .if_valid(z_if_valid),
    .d_req(z_d_req), .d_we(z_d_we), .d_be(z_d_be), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_rdata(z_d_rdata), .d_valid(z_d_valid), .d_err(z_d_err), .stall(z_stall)
  );

  task automatic d_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    bit done;
    done = 1'b0; lat = 0; rdata = '0; err = 1'b0;
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (d_valid) begin
        rdata = d_rdata; err = d_err; d_req = 1'b0; done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++; d_req = 1'b0;
      $display("FAIL d_xfer_timeout: addr %h saw no d_valid, required within 20 cycles", addr);
    end
  endtask

  task automatic f_xfer(input logic [31:0] addr, output logic [31:0] rdata, output int lat,
                        output int stall_cnt, output logic stall_at_valid);
    bit done;
    done = 1'b0; lat = 0; rdata = '0; stall_at_valid = 1'b1;
    if_req = 1'b1; if_addr = addr;
    #1;
    stall_cnt = stall ? 1 : 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (if_valid) begin
        rdata = if_rdata; stall_at_valid = stall; if_req = 1'b0; done = 1'b1;
      end else if (stall) begin
        stall_cnt++;
      end
    end
    if (!done) begin
      n_tests++; n_fail++; if_req = 1'b0;
      $display("FAIL f_xfer_timeout: addr %h saw no if_valid, required within 20 cycles", addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if ({if_valid, d_valid, d_err, stall} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {if_valid, d_valid, d_err, stall}); end
    n_tests++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++;
      $display("FAIL reset_rdata: got %h required 0", {if_rdata, d_rdata}); end
    rst_n = 1'b1;
    d_req = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++;
      $display("FAIL reset_stall_comb: got %b required 1", stall); end
    d_req = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] r; logic e, sv; int lat, sc;
    d_xfer(1'b1, 4'hF, 32'h10, 32'h0050_0093, r, e, lat);
    n_tests++; if (lat !== 3 || e !== 1'b0) begin n_fail++;
      $display("FAIL preload_write: got lat %0d err %b required lat 3 err 0", lat, e); end
    f_xfer(32'h10, r, lat, sc, sv);
    n_tests++; if (lat !== 3) begin n_fail++;
      $display("FAIL fetch_latency: got %0d required 3", lat); end
    n_tests++; if (r !== 32'h0050_0093) begin n_fail++;
      $display("FAIL fetch_rdata: got %h required 00500093", r); end
    n_tests++; if (sc !== 3 || sv !== 1'b0) begin n_fail++;
      $display("FAIL fetch_stall: got %0d cycles (at valid %b) required 3 (0)", sc, sv); end
    repeat (2) begin @(posedge clk); #1; end
    n_tests++; if (if_valid !== 1'b0 || if_rdata !== 32'h0050_0093) begin n_fail++;
      $display("FAIL fetch_hold: got valid %b rdata %h required 0 00500093", if_valid, if_rdata); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] r, idata; logic e; int lat, cyc, dcyc, icyc;
    d_xfer(1'b1, 4'hF, 32'h0, 32'h1357_9BDF, r, e, lat);
    cyc = 0; dcyc = -1; icyc = -1; idata = '0;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 30 && (d_req || if_req); i++) begin
      @(posedge clk); #1;
      cyc++;
      if (d_valid && d_req) begin dcyc = cyc; d_req = 1'b0; end
      if (if_valid && if_req) begin icyc = cyc; idata = if_rdata; if_req = 1'b0; end
    end
    d_req = 1'b0; if_req = 1'b0;
    n_tests++; if (dcyc !== 3 || icyc !== 6) begin n_fail++;
      $display("FAIL arb_order: got d_valid@%0d if_valid@%0d required 3 and 6", dcyc, icyc); end
    n_tests++; if (idata !== 32'h1357_9BDF) begin n_fail++;
      $display("FAIL arb_fetch_data: got %h required 13579bdf", idata); end
    d_xfer(1'b0, 4'h0, 32'h40, 32'h0, r, e, lat);
    n_tests++; if (r !== 32'hDEAD_BEEF || e !== 1'b0) begin n_fail++;
      $display("FAIL arb_readback: got %h err %b required deadbeef 0", r, e); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] r; logic e; int lat;
    d_xfer(1'b1, 4'hF, 32'h40, 32'h1122_3344, r, e, lat);
    d_xfer(1'b1, 4'b0010, 32'h40, 32'h0000_AA00, r, e, lat);
    d_xfer(1'b0, 4'h0, 32'h40, 32'h0, r, e, lat);
    n_tests++; if (r !== 32'h1122_AA44) begin n_fail++;
      $display("FAIL byte_enable: got %h required 1122aa44", r); end
    d_xfer(1'b1, 4'hF, 32'h44, 32'h7777_7777, r, e, lat);
    n_tests++; if (r !== 32'h1122_AA44 || d_rdata !== 32'h1122_AA44) begin n_fail++;
      $display("FAIL write_holds_rdata: got %h/%h required 1122aa44", r, d_rdata); end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e, sv; int lat, sc;
    d_xfer(1'b1, 4'hF, 32'h42, 32'hFFFF_FFFF, r, e, lat);
    n_tests++; if (e !== 1'b1 || r !== 32'h0) begin n_fail++;
      $display("FAIL misaligned_write: got err %b rdata %h required 1 0", e, r); end
    d_xfer(1'b0, 4'h0, 32'h40, 32'h0, r, e, lat);
    n_tests++; if (e !== 1'b0 || r !== 32'h1122_AA44) begin n_fail++;
      $display("FAIL misaligned_no_write: got err %b rdata %h required 0 1122aa44", e, r); end
    d_xfer(1'b0, 4'h0, 32'h1000, 32'h0, r, e, lat);
    n_tests++; if (e !== 1'b1 || r !== 32'h0) begin n_fail++;
      $display("FAIL range_read: got err %b rdata %h required 1 0", e, r); end
    d_xfer(1'b1, 4'hF, 32'hFFC, 32'hA5A5_0FFC, r, e, lat);
    d_xfer(1'b0, 4'h0, 32'hFFC, 32'h0, r, e, lat);
    n_tests++; if (e !== 1'b0 || r !== 32'hA5A5_0FFC) begin n_fail++;
      $display("FAIL last_word: got err %b rdata %h required 0 a5a50ffc", e, r); end
    d_xfer(1'b1, 4'hF, 32'h1000, 32'h0BAD_0BAD, r, e, lat);
    d_xfer(1'b0, 4'h0, 32'h0, 32'h0, r, e, lat);
    n_tests++; if (r !== 32'h1357_9BDF) begin n_fail++;
      $display("FAIL range_write_no_wrap: got %h required 13579bdf", r); end
    f_xfer(32'h2000, r, lat, sc, sv);
    n_tests++; if (r !== 32'h0 || lat !== 3) begin n_fail++;
      $display("FAIL fetch_error: got rdata %h lat %0d required 0 3", r, lat); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r; logic e, sv; int lat, sc;
    d_xfer(1'b1, 4'hF, 32'h80, 32'h5A5A_5A5A, r, e, lat);
    d_xfer(1'b0, 4'h0, 32'h80, 32'h0, r, e, lat);
    f_xfer(32'h10, r, lat, sc, sv);
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h80; d_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b0;
    #1;
    n_tests++; if ({if_valid, d_valid, d_err} !== 3'b000 || {if_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_abort_outputs: got %b %h %h required 000 0 0",
               {if_valid, d_valid, d_err}, if_rdata, d_rdata); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    d_xfer(1'b0, 4'h0, 32'h80, 32'h0, r, e, lat);
    n_tests++; if (r !== 32'h5A5A_5A5A || lat !== 3) begin n_fail++;
      $display("FAIL reset_abort_mem: got %h lat %0d required 5a5a5a5a 3", r, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [31:0] got [3];
    int vcyc [3];
    int idx, cyc;
    vals[0] = 32'h0000_0013; vals[1] = 32'h0040_0113; vals[2] = 32'hDEAD_0008;
    for (int k = 0; k < 3; k++) begin
      z_d_req = 1'b1; z_d_we = 1'b1; z_d_be = 4'hF; z_d_addr = 32'(4 * k); z_d_wdata = vals[k];
      for (int i = 0; i < 10 && z_d_req; i++) begin
        @(posedge clk); #1;
        if (z_d_valid) z_d_req = 1'b0;
      end
      z_d_req = 1'b0;
    end
    idx = 0; cyc = 0;
    for (int k = 0; k < 3; k++) begin got[k] = '0; vcyc[k] = -1; end
    z_d_req = 1'b1; z_d_we = 1'b0; z_d_addr = 32'h0;
    for (int i = 0; i < 20 && idx < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (z_d_valid) begin
        got[idx] = z_d_rdata; vcyc[idx] = cyc; idx++;
        if (idx == 3) z_d_req = 1'b0;
        else          z_d_addr = 32'(4 * idx);
      end
    end
    z_d_req = 1'b0;
    n_tests++; if (vcyc[0] !== 1 || vcyc[1] !== 2 || vcyc[2] !== 3) begin n_fail++;
      $display("FAIL b2b_timing: got valid at %0d %0d %0d required 1 2 3", vcyc[0], vcyc[1], vcyc[2]); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (got[k] !== vals[k]) begin n_fail++;
        $display("FAIL b2b_data%0d: got %h required %h", k, got[k], vals[k]); end
    end
    @(posedge clk); #1;
    n_tests++; if (z_d_valid !== 1'b0 || z_d_rdata !== vals[2]) begin n_fail++;
      $display("FAIL b2b_hold: got valid %b rdata %h required 0 %h", z_d_valid, z_d_rdata, vals[2]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_byte_enable();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 Parameter XLEN, 32, data and address width in bits (multiple of 8).
REQ-002 Parameter DEPTH_WORDS, 1024, memory depth in XLEN-bit words (power of 2).
REQ-003 Parameter WAIT_STATES, 1, extra access cycles per transfer (0..15).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch request, level, held until if_valid.
REQ-007 if_addr  in  XLEN  fetch byte address, stable while if_req.
REQ-008 if_rdata  out  XLEN  fetched word, valid when if_valid.
REQ-009 if_valid  out  1  one-cycle fetch completion pulse.
REQ-010 d_req  in  1  data request, level, held until d_valid.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_be  in  XLEN/8  byte enables for writes.
REQ-013 d_addr  in  XLEN  data byte address.
REQ-014 d_wdata  in  XLEN  write data.
REQ-015 d_rdata  out  XLEN  read data, valid when d_valid and d_we=0.
REQ-016 d_valid  out  1  one-cycle data completion pulse.
REQ-017 d_err  out  1  pulses with d_valid on misaligned or out-of-range data access.
REQ-018 stall  out  1  high when any request is asserted and its valid is not high this cycle.

Function
REQ-019 One shared single-port memory SHALL serve both ports; at most one access in flight.
REQ-020 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any request; ACCESS->RESP when the wait counter reaches WAIT_STATES; RESP->ACCESS if another request is pending, else IDLE.
REQ-021 WAIT_STATES=0 SHALL skip ACCESS dwell; latency from request sample to valid = WAIT_STATES+1 cycles.
REQ-022 Simultaneous if_req and d_req: data SHALL be granted first; fetch granted the cycle after d_valid with no idle cycle.
REQ-023 Grant SHALL be latched at IDLE/RESP exit; requester changes during ACCESS are ignored.
REQ-024 Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0]!=0 is misaligned.
REQ-025 Write SHALL commit only enabled bytes, on the ACCESS->RESP edge, exactly once.
REQ-026 Misaligned or addr >= 4*DEPTH_WORDS: no write, rdata = 0, d_err=1 with d_valid; fetch errors return 0 with if_valid.
REQ-027 On writes d_rdata SHALL hold its previous value.
REQ-028 if_rdata/d_rdata SHALL hold last value between valid pulses.
REQ-029 A request deasserted before its valid is a protocol violation; behaviour undefined, no assertion.

Reset
REQ-030 Reset low SHALL force IDLE, counter 0, if_valid=d_valid=d_err=0, if_rdata=d_rdata=0, stall combinational.
REQ-031 Reset mid-ACCESS SHALL abort with no write committed; memory contents are not cleared.
REQ-032 First grant SHALL occur the first rising edge after reset deasserts.

Structure
REQ-033 Package mem_pkg SHALL hold the state enum, grant enum (GNT_I, GNT_D) and log2 address-width constant.
REQ-034 Sub-module sp_ram: single-port, byte-enabled, synchronous-write/read XLEN x DEPTH_WORDS array; controller owns all sequencing.

Verification
REQ-035 WAIT_STATES=2, read fetch addr 0x10 preloaded 0x00500093 -> if_valid 3 cycles after req, if_rdata=0x00500093, stall high 3 cycles.
REQ-036 Simultaneous if_req addr 0x0 and d_req write 0xDEADBEEF to 0x40 be=4'hF -> d_valid first, if_valid WAIT_STATES+1 cycles later; readback 0x40 = 0xDEADBEEF.
REQ-037 Word 0x40 = 0x11223344, write be=4'b0010 data 0x0000AA00 -> readback 0x1122AA44.
REQ-038 d_addr 0x42 write, then d_addr 0x1000 (DEPTH_WORDS=1024) read -> each d_err=1, d_rdata=0, memory unchanged.
REQ-039 Assert reset during ACCESS of write 0xCAFEF00D to 0x80 -> outputs zero, readback 0x80 unchanged.
REQ-040 WAIT_STATES=0, back-to-back reads 0x0, 0x4, 0x8 -> valid every cycle after first, no bubble.
